// File: rtl/rob_write_arbiter.sv
// Merges ALU and MUL (M5) completions onto one registered ROB write port.
// Each source has a one-entry holding buffer; the entry closer to the ROB head wins.
module rob_write_arbiter #(
    parameter int REGISTER_SIZE    = 32,
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int ID_SIZE          = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [ID_SIZE-1:0]          rob_head,

    input  logic                        alu_req,
    input  logic [ID_SIZE-1:0]          alu_id,
    input  logic [REG_ADDRESS_SIZE-1:0] alu_address,
    input  logic [REGISTER_SIZE-1:0]    alu_data,
    input  logic                        alu_w,
    output logic                        alu_stall,

    input  logic                        mul_req,
    input  logic [ID_SIZE-1:0]          mul_id,
    input  logic [REG_ADDRESS_SIZE-1:0] mul_address,
    input  logic [REGISTER_SIZE-1:0]    mul_data,
    input  logic                        mul_w,
    output logic                        mul_stall,

    output logic                        rob_req,
    output logic [ID_SIZE-1:0]          rob_id,
    output logic [REG_ADDRESS_SIZE-1:0] rob_address,
    output logic [REGISTER_SIZE-1:0]    rob_data,
    output logic                        rob_w,
    input  logic                        rob_stall
);

    typedef struct packed {
        logic [ID_SIZE-1:0]          id;
        logic [REG_ADDRESS_SIZE-1:0] address;
        logic [REGISTER_SIZE-1:0]    data;
        logic                        w;
    } entry_t;

    entry_t alu_in, mul_in;
    entry_t buf_a, buf_m;
    entry_t out_q;
    logic   valid_a, valid_m;

    logic               out_free;
    logic [ID_SIZE-1:0] age_a, age_m;
    logic               grant_a, grant_m;
    logic               load_a, load_m;

    assign alu_in = '{id: alu_id, address: alu_address, data: alu_data, w: alu_w};
    assign mul_in = '{id: mul_id, address: mul_address, data: mul_data, w: mul_w};

    assign out_free = !rob_req || !rob_stall;

    // Distance from the head modulo 2^ID_SIZE; the truncating subtract handles wrap.
    assign age_a = buf_a.id - rob_head;
    assign age_m = buf_m.id - rob_head;

    // Equal ages can only come from a duplicate id; A wins the tie.
    assign grant_a = out_free && valid_a && (!valid_m || (age_a <= age_m));
    assign grant_m = out_free && valid_m && (!valid_a || (age_m <  age_a));

    assign alu_stall = !flush && valid_a && !grant_a;
    assign mul_stall = !flush && valid_m && !grant_m;

    assign load_a = !flush && alu_req && !alu_stall;
    assign load_m = !flush && mul_req && !mul_stall;

    assign rob_id      = out_q.id;
    assign rob_address = out_q.address;
    assign rob_data    = out_q.data;
    assign rob_w       = out_q.w;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_a <= 1'b0;
            valid_m <= 1'b0;
            rob_req <= 1'b0;
            out_q   <= '0;
        end else if (flush) begin
            valid_a <= 1'b0;
            valid_m <= 1'b0;
            rob_req <= 1'b0;
        end else begin
            if (grant_a) begin
                rob_req <= 1'b1;
                out_q   <= buf_a;
            end else if (grant_m) begin
                rob_req <= 1'b1;
                out_q   <= buf_m;
            end else if (out_free) begin
                rob_req <= 1'b0;
            end

            if (load_a)       valid_a <= 1'b1;
            else if (grant_a) valid_a <= 1'b0;

            if (load_m)       valid_m <= 1'b1;
            else if (grant_m) valid_m <= 1'b0;
        end
    end

    // NOTE: buffer payloads carry no reset; they are only observed while their valid
    // bit is set, so a reset would add fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        if (load_a) buf_a <= alu_in;
        if (load_m) buf_m <= mul_in;
    end

endmodule

// File: tb/tb_rob_write_arbiter.sv
// Directed bench for rob_write_arbiter: arbitration order, wrap, back-pressure,
// flush and asynchronous reset, each against hand-computed expectations.
module tb_rob_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  rob_head = '0;
    logic        alu_req = 1'b0, mul_req = 1'b0, rob_stall = 1'b0;
    logic [1:0]  alu_id = '0, mul_id = '0;
    logic [4:0]  alu_address = '0, mul_address = '0;
    logic [31:0] alu_data = '0, mul_data = '0;
    logic        alu_w = 1'b0, mul_w = 1'b0;
    logic        alu_stall, mul_stall;
    logic        rob_req, rob_w;
    logic [1:0]  rob_id;
    logic [4:0]  rob_address;
    logic [31:0] rob_data;

    int vectors = 0;
    int miscompares = 0;

    logic [40:0] got;
    assign got = {rob_req, rob_id, rob_address, rob_data, rob_w};

    rob_write_arbiter #(.REGISTER_SIZE(32), .REG_ADDRESS_SIZE(5), .ID_SIZE(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .rob_head(rob_head),
        .alu_req(alu_req), .alu_id(alu_id), .alu_address(alu_address),
        .alu_data(alu_data), .alu_w(alu_w), .alu_stall(alu_stall),
        .mul_req(mul_req), .mul_id(mul_id), .mul_address(mul_address),
        .mul_data(mul_data), .mul_w(mul_w), .mul_stall(mul_stall),
        .rob_req(rob_req), .rob_id(rob_id), .rob_address(rob_address),
        .rob_data(rob_data), .rob_w(rob_w), .rob_stall(rob_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Per-source payload patterns so a swapped source is visible in address/data/w.
    function automatic logic [40:0] alu_exp(input logic [1:0] id);
        return {1'b1, id, 5'd8 + 5'(id), 32'hA100_0000 + 32'(id), id[0]};
    endfunction

    function automatic logic [40:0] mul_exp(input logic [1:0] id);
        return {1'b1, id, 5'd16 + 5'(id), 32'hB200_0000 + 32'(id), ~id[0]};
    endfunction

    task automatic drive_alu(input logic req, input logic [1:0] id);
        alu_req = req; alu_id = id; alu_address = 5'd8 + 5'(id);
        alu_data = 32'hA100_0000 + 32'(id); alu_w = id[0];
    endtask

    task automatic drive_mul(input logic req, input logic [1:0] id);
        mul_req = req; mul_id = id; mul_address = 5'd16 + 5'(id);
        mul_data = 32'hB200_0000 + 32'(id); mul_w = ~id[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive_alu(1'b0, 2'd0); drive_mul(1'b0, 2'd0);
        flush = 1'b0; rob_stall = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (got !== 41'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=%h", got, 41'd0);
        end
        vectors++;
        if ({alu_stall, mul_stall} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_stalls got=%b exp=00", {alu_stall, mul_stall});
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_alu();
        alu_req = 1'b1; alu_id = 2'd1; alu_address = 5'd5; alu_data = 32'hDEADBEEF; alu_w = 1'b1;
        #1;
        vectors++;
        if (alu_stall !== 1'b0) begin
            miscompares++; $display("FAIL single_stall got=%b exp=0", alu_stall);
        end
        step();
        alu_req = 1'b0;
        vectors++;
        if (rob_req !== 1'b0) begin
            miscompares++; $display("FAIL single_early got=%b exp=0", rob_req);
        end
        step();
        vectors++;
        if (got !== {1'b1, 2'd1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
            miscompares++;
            $display("FAIL single_write got=%h exp=%h", got, {1'b1, 2'd1, 5'd5, 32'hDEADBEEF, 1'b1});
        end
        step();
        vectors++;
        if (rob_req !== 1'b0) begin
            miscompares++; $display("FAIL single_drop got=%b exp=0", rob_req);
        end
    endtask

    task automatic test_both_same_cycle();
        rob_head = 2'd0;
        drive_alu(1'b1, 2'd2); drive_mul(1'b1, 2'd1);
        step();
        // ALU offers a further completion while its buffered one loses arbitration.
        drive_alu(1'b1, 2'd3); drive_mul(1'b0, 2'd0);
        #1;
        vectors++;
        if ({alu_stall, mul_stall} !== 2'b10) begin
            miscompares++; $display("FAIL both_stalls got=%b exp=10", {alu_stall, mul_stall});
        end
        step();
        vectors++;
        if (got !== mul_exp(2'd1)) begin
            miscompares++; $display("FAIL both_first got=%h exp=%h", got, mul_exp(2'd1));
        end
        #1;
        vectors++;
        if (alu_stall !== 1'b0) begin
            miscompares++; $display("FAIL both_unstall got=%b exp=0", alu_stall);
        end
        step();
        drive_alu(1'b0, 2'd0);
        vectors++;
        if (got !== alu_exp(2'd2)) begin
            miscompares++; $display("FAIL both_second got=%h exp=%h", got, alu_exp(2'd2));
        end
        step();
        vectors++;
        if (got !== alu_exp(2'd3)) begin
            miscompares++; $display("FAIL both_third got=%h exp=%h", got, alu_exp(2'd3));
        end
        idle(2);
    endtask

    task automatic test_wrap();
        rob_head = 2'd3;
        drive_alu(1'b1, 2'd0); drive_mul(1'b1, 2'd3);
        step();
        drive_alu(1'b0, 2'd0); drive_mul(1'b0, 2'd0);
        step();
        vectors++;
        if (got !== mul_exp(2'd3)) begin
            miscompares++; $display("FAIL wrap_first got=%h exp=%h", got, mul_exp(2'd3));
        end
        step();
        vectors++;
        if (got !== alu_exp(2'd0)) begin
            miscompares++; $display("FAIL wrap_second got=%h exp=%h", got, alu_exp(2'd0));
        end
        idle(2);
        rob_head = 2'd0;
    endtask

    task automatic test_back_pressure();
        logic [40:0] held;
        logic [40:0] order [4];
        order[0] = alu_exp(2'd0); order[1] = mul_exp(2'd1);
        order[2] = alu_exp(2'd2); order[3] = mul_exp(2'd3);
        rob_head = 2'd0;
        drive_alu(1'b1, 2'd0); drive_mul(1'b1, 2'd1);
        step();
        drive_alu(1'b1, 2'd2); drive_mul(1'b0, 2'd0);
        step();
        drive_alu(1'b0, 2'd0); drive_mul(1'b1, 2'd3);
        rob_stall = 1'b1;
        held = alu_exp(2'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if ({alu_stall, mul_stall} !== 2'b11) begin
                miscompares++;
                $display("FAIL bp_stalls[%0d] got=%b exp=11", k, {alu_stall, mul_stall});
            end
            vectors++;
            if (got !== held) begin
                miscompares++; $display("FAIL bp_hold[%0d] got=%h exp=%h", k, got, held);
            end
            step();
        end
        rob_stall = 1'b0;
        #1;
        vectors++;
        if ({alu_stall, mul_stall} !== 2'b10) begin
            miscompares++; $display("FAIL bp_release got=%b exp=10", {alu_stall, mul_stall});
        end
        step();
        drive_mul(1'b0, 2'd0);
        for (int k = 1; k < 4; k++) begin
            vectors++;
            if (got !== order[k]) begin
                miscompares++; $display("FAIL bp_order[%0d] got=%h exp=%h", k, got, order[k]);
            end
            step();
        end
        vectors++;
        if (rob_req !== 1'b0) begin
            miscompares++; $display("FAIL bp_no_dup got=%b exp=0", rob_req);
        end
        idle(1);
    endtask

    task automatic test_flush();
        rob_head = 2'd0;
        drive_alu(1'b1, 2'd1); drive_mul(1'b1, 2'd2);
        step();
        drive_alu(1'b0, 2'd0); drive_mul(1'b0, 2'd0);
        step();
        vectors++;
        if (got !== alu_exp(2'd1)) begin
            miscompares++; $display("FAIL flush_pre got=%h exp=%h", got, alu_exp(2'd1));
        end
        // Flush together with ROB back-pressure and a new ALU completion.
        flush = 1'b1; rob_stall = 1'b1; drive_alu(1'b1, 2'd3);
        #1;
        vectors++;
        if ({alu_stall, mul_stall} !== 2'b00) begin
            miscompares++; $display("FAIL flush_stalls got=%b exp=00", {alu_stall, mul_stall});
        end
        step();
        flush = 1'b0; rob_stall = 1'b0; drive_alu(1'b0, 2'd0);
        vectors++;
        if ({rob_req, alu_stall, mul_stall} !== 3'b000) begin
            miscompares++;
            $display("FAIL flush_after got=%b exp=000", {rob_req, alu_stall, mul_stall});
        end
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (rob_req !== 1'b0) begin
                miscompares++; $display("FAIL flush_leak[%0d] got=%h exp=req 0", k, got);
            end
        end
    endtask

    task automatic test_async_reset();
        rob_head = 2'd0;
        drive_alu(1'b1, 2'd0); drive_mul(1'b1, 2'd1);
        step();
        drive_alu(1'b0, 2'd0); drive_mul(1'b0, 2'd0);
        step();
        #3;
        reset = 1'b0;
        #1;
        vectors++;
        if ({rob_req, alu_stall, mul_stall} !== 3'b000) begin
            miscompares++;
            $display("FAIL areset_drop got=%b exp=000", {rob_req, alu_stall, mul_stall});
        end
        #2;
        reset = 1'b1;
        drive_mul(1'b1, 2'd2);
        step();
        drive_mul(1'b0, 2'd0);
        vectors++;
        if (rob_req !== 1'b0) begin
            miscompares++; $display("FAIL areset_early got=%b exp=0", rob_req);
        end
        step();
        vectors++;
        if (got !== mul_exp(2'd2)) begin
            miscompares++; $display("FAIL areset_write got=%h exp=%h", got, mul_exp(2'd2));
        end
        step();
        vectors++;
        if (rob_req !== 1'b0) begin
            miscompares++; $display("FAIL areset_only_one got=%h exp=req 0", got);
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        idle(1);
        test_both_same_cycle();
        test_wrap();
        test_back_pressure();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rob_write_arbiter.md
# rob_write_arbiter

Merges the ALU and MUL pipeline completions onto a single registered ROB write port, replacing the two dedicated ROB write ports. Each pipeline gets a one-entry holding buffer. When both buffers hold a completion, the arbiter grants the older one, measured by ROB id distance from the ROB head. The block sits between the ALU_ROB/M5_ROB pipeline registers and the ROB, and returns per-source stalls to the ALU and M5 stages.

## Interface
Parameters:
- REGISTER_SIZE, 32, data width
- REG_ADDRESS_SIZE, 5, destination register address width
- ID_SIZE, 2, ROB id width; ids wrap modulo 2^ID_SIZE

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; asserted while 0
- flush  in  1  synchronous discard of all buffered and output entries (branch taken)
- rob_head  in  ID_SIZE  id of oldest uncommitted ROB entry
- alu_req  in  1  ALU completion valid
- alu_id  in  ID_SIZE  ROB id of ALU completion
- alu_address  in  REG_ADDRESS_SIZE  destination register
- alu_data  in  REGISTER_SIZE  result
- alu_w  in  1  register-write flag
- alu_stall  out  1  ALU must hold its completion
- mul_req, mul_id, mul_address, mul_data, mul_w  in  same widths as alu_*  MUL (M5) completion
- mul_stall  out  1  M5 must hold its completion
- rob_req  out  1  registered: write valid
- rob_id  out  ID_SIZE  registered
- rob_address  out  REG_ADDRESS_SIZE  registered
- rob_data  out  REGISTER_SIZE  registered
- rob_w  out  1  registered
- rob_stall  in  1  ROB cannot accept; hold rob_* unchanged

## Operation
- State:
  - two buffers, A (ALU) and M (MUL); each has a valid bit and a {id, address, data, w} payload.
  - one output register, driving rob_*.
- out_free = !rob_req || !rob_stall.
- Candidates: every valid buffer.
- Age: age = (id - rob_head) mod 2^ID_SIZE; smaller age is older.
- Grant:
  - If out_free and exactly one candidate: grant it.
  - If out_free and two candidates: grant the smaller age.
  - Equal ages indicate an illegal duplicate id; grant A.
  - No grant when !out_free.
- Output register:
  - On grant: load the granted payload and set rob_req=1.
  - Else if out_free: rob_req=0.
  - Else: hold.
- Buffer X (A or M):
  - drains_X = grant_X.
  - X_stall = valid_X && !drains_X. This is combinational from rob_stall and rob_head.
  - At each edge, if X_req && !X_stall: load the payload and set valid.
  - Else if drains_X: clear valid.
  - A buffer drains and refills on the same edge; sustained throughput is 1 per cycle per free source.
- Inputs never bypass the buffers straight to the output register.
- flush=1:
  - At the next edge: clear both valid bits and rob_req; inputs presented that cycle are discarded.
  - alu_stall and mul_stall are forced to 0 during flush.
  - flush has priority over grant and load.
- Unused fields of an invalid buffer or output are don't-care. The bench checks them only when the corresponding valid or req is 1.

## Timing
- Reset (reset=0): asynchronously clears valid_A, valid_M, rob_req, rob_id, rob_address, rob_data and rob_w to 0. alu_stall and mul_stall are then 0.
- Latency: a completion accepted at edge N appears on rob_* after edge N+1 if granted in cycle N+1. Minimum latency is 2 edges.
- Loser of arbitration: stays buffered and is granted in the next out_free cycle unless an older entry arrives. Its source stalls while the buffer is full and not draining.
- rob_stall held for k cycles:
  - rob_* stay stable for those k cycles.
  - Both buffers fill.
  - Both sources stall until the first out_free cycle.
- rob_head wrap: with ID_SIZE=2 and rob_head=3, id 3 has age 0 and id 0 has age 1.
- A reset deassertion mid-stream leaves the block empty; the first new request is accepted at the first edge.
- Simultaneous flush and rob_stall: flush wins and rob_req=0 after the edge.

## Test plan
- Single ALU: alu_req=1 with id=1, address=5, data=0xDEADBEEF, w=1, at edge 0 -> rob_req=1 with those fields after edge 1, alu_stall always 0.
- Both sources, same cycle: rob_head=0, alu_id=2, mul_id=1 -> MUL granted first (rob_id=1); alu_stall=1 for one cycle if alu_req is held; ALU entry (rob_id=2) appears on the next cycle.
- Wrap-around: rob_head=3, alu_id=0, mul_id=3 -> rob_id=3 first, then 0.
- Back-pressure: rob_stall=1 for 3 cycles while both sources stream -> rob_* stable, both buffers full, alu_stall=mul_stall=1. After release, one write per cycle, oldest first, no loss or duplication.
- Flush: both buffers valid and rob_req=1, flush=1 for one cycle -> rob_req=0 and no stalls after the edge; no flushed id is ever written.
- Async reset: reset=0 mid-stream between clock edges -> rob_req, alu_stall and mul_stall drop to 0 immediately; after reset=1, id=2 from MUL is written 2 edges after acceptance.
